// File: rtl/misao_mem_bridge_if.sv
// Core/external memory bundle for the misao memory bridge.
// slave is the bridge view, master is the core plus memory side.
interface misao_mem_bridge_if;
  logic        core_rd;
  logic        core_wr;
  logic [14:0] core_addr;
  logic [7:0]  core_wdata;
  logic [7:0]  core_rdata;
  logic        core_ready;
  logic        ext_req;
  logic        ext_we;
  logic [14:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        err_clr;
  logic        bus_err;

  modport slave (
    input  core_rd,
    input  core_wr,
    input  core_addr,
    input  core_wdata,
    output core_rdata,
    output core_ready,
    output ext_req,
    output ext_we,
    output ext_addr,
    output ext_wdata,
    input  ext_rdata,
    input  ext_ack,
    input  err_clr,
    output bus_err
  );

  modport master (
    output core_rd,
    output core_wr,
    output core_addr,
    output core_wdata,
    input  core_rdata,
    input  core_ready,
    input  ext_req,
    input  ext_we,
    input  ext_addr,
    input  ext_wdata,
    output ext_rdata,
    output ext_ack,
    output err_clr,
    input  bus_err
  );
endinterface

// File: rtl/misao_mem_bridge.sv
// Bridge from the nibble core to byte-wide external memory:
// one-entry line buffer, posted-write FIFO and ack timeout.
module misao_mem_bridge #(
  parameter int WBUF_DEPTH  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  misao_mem_bridge_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0] DEPTH_C = 3'(WBUF_DEPTH);
  localparam logic [1:0] LAST_C = 2'(WBUF_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_e;

  state_e        state_q, state_d;
  logic          ext_req_q, ext_req_d;
  logic          ext_we_q, ext_we_d;
  logic [14:0]   ext_addr_q, ext_addr_d;
  logic [7:0]    ext_wdata_q, ext_wdata_d;
  logic          err_q, err_d;
  logic          lb_valid_q, lb_valid_d;
  logic [14:0]   lb_addr_q, lb_addr_d;
  logic [7:0]    lb_data_q, lb_data_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Sized for the largest legal depth; slots past WBUF_DEPTH stay idle.
  logic [14:0] wb_addr_q [4];
  logic [7:0]  wb_data_q [4];

  logic rd_hit;
  logic rd_miss;
  logic wr_acc;
  logic done;
  logic tmo_hit;
  logic push;
  logic pop;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == LAST_C) ? 2'd0 : p + 2'd1;
  endfunction

  assign rd_hit = bus.core_rd & lb_valid_q &
                  (bus.core_addr == lb_addr_q);
  assign rd_miss = bus.core_rd & ~bus.core_wr & ~rd_hit;
  assign wr_acc = bus.core_wr & (cnt_q < DEPTH_C);
  assign done = ext_req_q & bus.ext_ack;
  assign tmo_hit = ext_req_q & ~bus.ext_ack &
                   (tmo_q == TMO_LIM);
  assign push = wr_acc;

  assign bus.core_ready = rst &
    (wr_acc | (~bus.core_wr & rd_hit));
  assign bus.core_rdata = lb_data_q;
  assign bus.ext_req    = ext_req_q;
  assign bus.ext_we     = ext_we_q;
  assign bus.ext_addr   = ext_addr_q;
  assign bus.ext_wdata  = ext_wdata_q;
  assign bus.bus_err    = err_q;

  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    err_d       = err_q;
    lb_valid_d  = lb_valid_q;
    lb_addr_d   = lb_addr_q;
    lb_data_d   = lb_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != 3'd0) begin
          state_d     = S_WR;
          ext_req_d   = 1'b1;
          ext_we_d    = 1'b1;
          ext_addr_d  = wb_addr_q[rd_ptr_q];
          ext_wdata_d = wb_data_q[rd_ptr_q];
          tmo_d       = '0;
        end else if (rd_miss) begin
          state_d    = S_RD;
          ext_req_d  = 1'b1;
          ext_we_d   = 1'b0;
          ext_addr_d = bus.core_addr;
          tmo_d      = '0;
        end
      end
      S_WR, S_RD: begin
        if (done | tmo_hit) begin
          state_d   = S_IDLE;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          tmo_d     = '0;
          if (state_q == S_WR) begin
            pop = 1'b1;
          end else begin
            lb_valid_d = 1'b1;
            lb_addr_d  = ext_addr_q;
            lb_data_d  = done ? bus.ext_rdata : 8'h00;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        ext_req_d = 1'b0;
        ext_we_d  = 1'b0;
      end
    endcase

    // A newer core write beats any fill landing on the same edge.
    if (push && lb_valid_d &&
        bus.core_addr == lb_addr_d) begin
      lb_data_d = bus.core_wdata;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    if (bus.err_clr) err_d = 1'b0;
    if (tmo_hit)     err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      err_q       <= 1'b0;
      lb_valid_q  <= 1'b0;
      lb_addr_q   <= '0;
      lb_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      err_q       <= err_d;
      lb_valid_q  <= lb_valid_d;
      lb_addr_q   <= lb_addr_d;
      lb_data_q   <= lb_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else if (push) begin
      wb_addr_q[wr_ptr_q] <= bus.core_addr;
      wb_data_q[wr_ptr_q] <= bus.core_wdata;
    end
  end

endmodule
